// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory responder with a fixed number of
// waitrequest cycles per access, byte-lane writes, sticky protocol-error flag
// and modulo-2^16 read/write completion counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no access in progress; a new request starts the wait sequence
// S_WAIT   | stalling the initiator while the wait counter runs down
// S_ACCEPT | waitrequest released; the pending request completes here
module mem_responder #(
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   mem_address,
  input  logic [DATA_WIDTH/8-1:0] mem_byteenable,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [DATA_WIDTH-1:0]   mem_writedata,
  output logic                    mem_waitrequest,
  output logic [DATA_WIDTH-1:0]   mem_readdata,
  output logic                    mem_readdataready,
  output logic                    err,
  output logic [15:0]             rd_count,
  output logic [15:0]             wr_count
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCEPT = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic                    req;
  logic                    complete;
  logic [DEPTH_LOG2-1:0]   index;

  // Storage powers up cleared and is deliberately left out of reset.
  logic [DATA_WIDTH-1:0]   storage [DEPTH] = '{default: '0};

  // Upper address bits alias onto the same words and are intentionally unused.
  logic                    unused_addr_hi;

  assign req            = mem_read | mem_write;
  assign index          = mem_address[DEPTH_LOG2-1:0];
  assign unused_addr_hi = ^mem_address;
  assign complete       = req & ~mem_waitrequest;

  // Stall every request until ACCEPT; with no wait cycles IDLE accepts directly.
  always_comb begin
    mem_waitrequest = 1'b0;
    if (req && state != S_ACCEPT) begin
      if (!(WAIT_CYCLES == 0 && state == S_IDLE)) begin
        mem_waitrequest = 1'b1;
      end
    end
  end

  // Control FSM plus registered read data, error flag and completion counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      wait_cnt          <= 4'd0;
      mem_readdataready <= 1'b0;
      mem_readdata      <= '0;
      err               <= 1'b0;
      rd_count          <= 16'd0;
      wr_count          <= 16'd0;
    end else begin
      mem_readdataready <= 1'b0;

      // A simultaneous read and write is served as a write but flagged.
      if (mem_read && mem_write) begin
        err <= 1'b1;
      end

      if (complete) begin
        if (mem_write) begin
          wr_count <= wr_count + 16'd1;
        end else begin
          rd_count          <= rd_count + 16'd1;
          mem_readdata      <= storage[index];
          mem_readdataready <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (req && WAIT_CYCLES > 0) begin
            wait_cnt <= 4'(WAIT_CYCLES - 1);
            // The IDLE cycle already counts as one stall cycle, so a single
            // wait cycle has nothing left to do in WAIT.
            state    <= (WAIT_CYCLES == 1) ? S_ACCEPT : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!req) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            err      <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt <= 4'd1) begin
              state <= S_ACCEPT;
            end
          end
        end
        S_ACCEPT: begin
          state    <= S_IDLE;
          wait_cnt <= 4'd0;
        end
        default: begin
          state    <= S_IDLE;
          wait_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Byte-lane write at the completion edge; an edge seen under reset never writes.
  always_ff @(posedge clock) begin
    if (!reset && complete && mem_write) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (mem_byteenable[b]) begin
          storage[index][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: a WAIT_CYCLES=2 instance exercised with
// directed and random accesses, and a WAIT_CYCLES=0 instance for streaming.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        reset;

  logic [19:0] mem_address;
  logic [1:0]  mem_byteenable;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_writedata;
  logic        mem_waitrequest;
  logic [15:0] mem_readdata;
  logic        mem_readdataready;
  logic        err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  logic [19:0] z_address;
  logic [1:0]  z_byteenable;
  logic        z_read;
  logic        z_write;
  logic [15:0] z_writedata;
  logic        z_waitrequest;
  logic [15:0] z_readdata;
  logic        z_readdataready;
  logic        z_err;
  logic [15:0] z_rd_count;
  logic [15:0] z_wr_count;

  int checks   = 0;
  int failures = 0;

  // Reference state for the WAIT_CYCLES=2 instance
  logic [15:0] mdl [1024];
  logic [15:0] mdl_rd;
  logic [15:0] mdl_wr;
  logic        mdl_err;
  // Reference storage for the WAIT_CYCLES=0 instance
  logic [15:0] mdl_z [1024];

  always #5 clock = ~clock;

  mem_responder #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut (
    .clock(clock), .reset(reset),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_read(mem_read), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .mem_readdataready(mem_readdataready), .err(err),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  mem_responder #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut_z (
    .clock(clock), .reset(reset),
    .mem_address(z_address), .mem_byteenable(z_byteenable),
    .mem_read(z_read), .mem_write(z_write), .mem_writedata(z_writedata),
    .mem_waitrequest(z_waitrequest), .mem_readdata(z_readdata),
    .mem_readdataready(z_readdataready), .err(z_err),
    .rd_count(z_rd_count), .wr_count(z_wr_count)
  );

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0]  = d[7:0];
    if (be[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  // One complete access on the WAIT_CYCLES=2 instance, checked against the model.
  task automatic access(input bit rd, input bit wr, input logic [19:0] a,
                        input logic [1:0] be, input logic [15:0] d);
    int          waits;
    bit          done;
    logic [15:0] exp_data;
    int          idx;
    idx = int'(a) % 1024;
    @(negedge clock);
    mem_address = a; mem_byteenable = be; mem_writedata = d;
    mem_read = rd; mem_write = wr;
    waits = 0; done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      if (mem_waitrequest) begin
        waits++;
        @(negedge clock);
      end else begin
        done = 1;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL access_timeout addr=%h waits=%0d required completion within 20", a, waits);
    end
    exp_data = mdl[idx];
    if (wr) begin
      mdl[idx] = merge(mdl[idx], d, be);
      mdl_wr   = mdl_wr + 16'd1;
      if (rd) mdl_err = 1'b1;
    end else begin
      mdl_rd = mdl_rd + 16'd1;
    end
    @(negedge clock);
    checks++;
    if (waits !== 2) begin
      failures++;
      $display("FAIL wait_cycles addr=%h actual=%0d required=2", a, waits);
    end
    checks++;
    if (mem_readdataready !== (rd && !wr)) begin
      failures++;
      $display("FAIL ready_pulse addr=%h actual=%b required=%b", a, mem_readdataready, rd && !wr);
    end
    if (rd && !wr) begin
      checks++;
      if (mem_readdata !== exp_data) begin
        failures++;
        $display("FAIL read_data addr=%h actual=%h required=%h", a, mem_readdata, exp_data);
      end
    end
    checks++;
    if (rd_count !== mdl_rd || wr_count !== mdl_wr || err !== mdl_err) begin
      failures++;
      $display("FAIL counters addr=%h actual rd=%0d wr=%0d err=%b required rd=%0d wr=%0d err=%b",
               a, rd_count, wr_count, err, mdl_rd, mdl_wr, mdl_err);
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clock);
    checks++;
    if (mem_readdataready !== 1'b0) begin
      failures++;
      $display("FAIL ready_single_cycle addr=%h actual=%b required=0", a, mem_readdataready);
    end
    if (rd && !wr) begin
      checks++;
      if (mem_readdata !== exp_data) begin
        failures++;
        $display("FAIL read_data_hold addr=%h actual=%h required=%h", a, mem_readdata, exp_data);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_byteenable = '0; mem_writedata = '0;
    z_read = 1'b0; z_write = 1'b0; z_address = '0; z_byteenable = '0; z_writedata = '0;
    repeat (3) @(negedge clock);
    checks++;
    if (mem_readdataready !== 1'b0 || mem_readdata !== 16'h0 || err !== 1'b0 ||
        rd_count !== 16'd0 || wr_count !== 16'd0 || mem_waitrequest !== 1'b0) begin
      failures++;
      $display("FAIL reset_state actual rdy=%b data=%h err=%b rd=%0d wr=%0d wrq=%b required all zero",
               mem_readdataready, mem_readdata, err, rd_count, wr_count, mem_waitrequest);
    end
    reset = 1'b0;
    mdl_rd = 16'd0; mdl_wr = 16'd0; mdl_err = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_directed();
    access(1'b0, 1'b1, 20'h00010, 2'b11, 16'hBEEF);
    checks++;
    if (wr_count !== 16'd1) begin
      failures++;
      $display("FAIL first_write_count actual=%0d required=1", wr_count);
    end
    access(1'b1, 1'b0, 20'h00010, 2'b00, 16'h0000);
    checks++;
    if (mem_readdata !== 16'hBEEF || rd_count !== 16'd1) begin
      failures++;
      $display("FAIL read_beef actual=%h rd=%0d required=beef rd=1", mem_readdata, rd_count);
    end
    access(1'b0, 1'b1, 20'h00010, 2'b01, 16'h1234);
    access(1'b1, 1'b0, 20'h00010, 2'b10, 16'h0000);
    checks++;
    if (mem_readdata !== 16'hBE34) begin
      failures++;
      $display("FAIL byte_lane_write actual=%h required=be34", mem_readdata);
    end
    access(1'b0, 1'b1, 20'h00400, 2'b11, 16'hAAAA);
    access(1'b1, 1'b0, 20'h00000, 2'b11, 16'h0000);
    checks++;
    if (mem_readdata !== 16'hAAAA) begin
      failures++;
      $display("FAIL address_alias actual=%h required=aaaa", mem_readdata);
    end
    access(1'b0, 1'b1, 20'h00010, 2'b00, 16'h5555);
    access(1'b1, 1'b0, 20'h00010, 2'b11, 16'h0000);
    checks++;
    if (mem_readdata !== 16'hBE34) begin
      failures++;
      $display("FAIL zero_byteenable actual=%h required=be34", mem_readdata);
    end
  endtask

  task automatic test_abort_wait();
    logic [15:0] rd_before;
    logic [15:0] wr_before;
    rd_before = mdl_rd; wr_before = mdl_wr;
    @(negedge clock);
    mem_address = 20'h00033; mem_byteenable = 2'b11; mem_writedata = 16'hDEAD; mem_write = 1'b1;
    @(negedge clock);
    mem_write = 1'b0;
    mdl_err = 1'b1;
    @(negedge clock);
    checks++;
    if (err !== 1'b1 || rd_count !== rd_before || wr_count !== wr_before || mem_readdataready !== 1'b0) begin
      failures++;
      $display("FAIL abort_in_wait actual err=%b rd=%0d wr=%0d rdy=%b required err=1 rd=%0d wr=%0d rdy=0",
               err, rd_count, wr_count, mem_readdataready, rd_before, wr_before);
    end
    access(1'b1, 1'b0, 20'h00033, 2'b11, 16'h0000);
  endtask

  task automatic test_reset_mid_access();
    access(1'b0, 1'b1, 20'h00020, 2'b11, 16'h0F0F);
    @(negedge clock);
    mem_address = 20'h00020; mem_byteenable = 2'b11; mem_writedata = 16'h5A5A; mem_write = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (mem_readdataready !== 1'b0 || rd_count !== 16'd0 || wr_count !== 16'd0 ||
        err !== 1'b0 || mem_readdata !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid_access actual rdy=%b rd=%0d wr=%0d err=%b data=%h required all zero",
               mem_readdataready, rd_count, wr_count, err, mem_readdata);
    end
    @(negedge clock);
    checks++;
    if (mem_readdataready !== 1'b0 || wr_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_hold actual rdy=%b wr=%0d required rdy=0 wr=0", mem_readdataready, wr_count);
    end
    reset = 1'b0; mem_write = 1'b0;
    mdl_rd = 16'd0; mdl_wr = 16'd0; mdl_err = 1'b0;
    access(1'b1, 1'b0, 20'h00020, 2'b11, 16'h0000);
    checks++;
    if (mem_readdata !== 16'h0F0F) begin
      failures++;
      $display("FAIL reset_no_write actual=%h required=0f0f", mem_readdata);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [19:0] a;
      bit          rd;
      a  = 20'(($urandom_range(0, 1023) << 10) | ($urandom_range(0, 15) * 7));
      rd = ($urandom_range(0, 1) == 1);
      access(rd, !rd, a, 2'($urandom_range(0, 3)), 16'($urandom));
    end
  endtask

  task automatic test_both_asserted();
    access(1'b1, 1'b1, 20'h00044, 2'b11, 16'hC0DE);
    access(1'b1, 1'b0, 20'h00044, 2'b11, 16'h0000);
    checks++;
    if (mem_readdata !== 16'hC0DE || err !== 1'b1) begin
      failures++;
      $display("FAIL read_write_together actual data=%h err=%b required data=c0de err=1", mem_readdata, err);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky actual=%b required=1", err);
    end
  endtask

  // WAIT_CYCLES=0: eight streamed writes followed directly by eight streamed reads.
  task automatic test_back_to_back();
    logic [19:0] wa [8];
    logic [19:0] ra [8];
    logic [15:0] exp_prev;
    for (int i = 0; i < 8; i++) wa[i] = 20'($urandom_range(0, 1023) | ($urandom_range(0, 3) << 12));
    ra[0] = wa[7];
    for (int i = 1; i < 8; i++) ra[i] = wa[$urandom_range(0, 7)];
    exp_prev = '0;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clock);
      checks++;
      if (z_readdataready !== (i >= 9)) begin
        failures++;
        $display("FAIL stream_ready cycle=%0d actual=%b required=%b", i, z_readdataready, i >= 9);
      end
      if (i >= 9) begin
        checks++;
        if (z_readdata !== exp_prev) begin
          failures++;
          $display("FAIL stream_read_data cycle=%0d actual=%h required=%h", i, z_readdata, exp_prev);
        end
      end
      if (i < 8) begin
        z_address = wa[i]; z_byteenable = 2'($urandom_range(0, 3));
        z_writedata = 16'($urandom); z_write = 1'b1; z_read = 1'b0;
        mdl_z[int'(wa[i]) % 1024] = merge(mdl_z[int'(wa[i]) % 1024], z_writedata, z_byteenable);
      end else if (i < 16) begin
        z_address = ra[i-8]; z_write = 1'b0; z_read = 1'b1;
        exp_prev = mdl_z[int'(ra[i-8]) % 1024];
      end else begin
        z_write = 1'b0; z_read = 1'b0;
      end
      if (i < 16) begin
        #1;
        checks++;
        if (z_waitrequest !== 1'b0) begin
          failures++;
          $display("FAIL stream_waitrequest cycle=%0d actual=%b required=0", i, z_waitrequest);
        end
      end
    end
    @(negedge clock);
    checks++;
    if (z_readdataready !== 1'b0 || z_rd_count !== 16'd8 || z_wr_count !== 16'd8 || z_err !== 1'b0) begin
      failures++;
      $display("FAIL stream_totals actual rdy=%b rd=%0d wr=%0d err=%b required rdy=0 rd=8 wr=8 err=0",
               z_readdataready, z_rd_count, z_wr_count, z_err);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mdl[i]   = 16'h0;
      mdl_z[i] = 16'h0;
    end
    test_reset();
    test_back_to_back();
    test_directed();
    test_abort_wait();
    test_reset_mid_access();
    test_random();
    test_both_asserted();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
